// File: rtl/serial_mod_fsm.sv
// Bit-serial running remainder mod MOD over framed input (sof/eof), MSB-first by default.
// Define SERIAL_MOD_LSB_FIRST_EN to build the wgt register and per-frame LSB-first order.
module serial_mod_fsm #(
   parameter  int MOD    = 5,
   parameter  int MAXLEN = 32,
   localparam int W      = ($clog2(MOD) < 1) ? 1 : $clog2(MOD),
   localparam int CW     = $clog2(MAXLEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          in_bit,
   input  logic          in_sof,
   input  logic          in_eof,
   input  logic          lsb_first,
   output logic [W-1:0]  rem,
   output logic          divisible,
   output logic          done,
   output logic          busy,
   output logic [CW-1:0] bit_cnt,
   output logic          ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [W:0]    MODW = (W+1)'(MOD);
   localparam logic [CW-1:0] MAXC = CW'(MAXLEN);

   state_t        state_q, state_d;
   logic [W-1:0]  rem_q, rem_d, rem_base, rem_upd;
   logic [CW-1:0] cnt_q, cnt_d, cnt_base;
   logic          ovf_q, ovf_d, ovf_base;
   logic          accept;
   logic [W:0]    msb_sum, msb_red;
   logic [W-1:0]  msb_rem;

   // A sof bit restarts the arithmetic from zero before folding in the current bit.
   assign accept   = in_valid && (in_sof || (state_q == RUN));
   assign rem_base = in_sof ? '0 : rem_q;
   assign cnt_base = in_sof ? '0 : cnt_q;
   assign ovf_base = in_sof ? 1'b0 : ovf_q;

   assign msb_sum = {rem_base, 1'b0} + {{W{1'b0}}, in_bit};
   assign msb_red = (msb_sum >= MODW) ? (msb_sum - MODW) : msb_sum;
   assign msb_rem = msb_red[W-1:0];

`ifdef SERIAL_MOD_LSB_FIRST_EN
   logic [W-1:0] wgt_q, wgt_d, wgt_base, lsb_rem, wgt_nxt;
   logic [W:0]   lsb_sum, lsb_red, wgt_dbl, wgt_red;
   logic         lsb_q, lsb_d, lsb_mode;

   assign wgt_base = in_sof ? W'(1) : wgt_q;
   assign lsb_mode = in_sof ? lsb_first : lsb_q;
   assign lsb_sum  = {1'b0, rem_base} + (in_bit ? {1'b0, wgt_base} : '0);
   assign lsb_red  = (lsb_sum >= MODW) ? (lsb_sum - MODW) : lsb_sum;
   assign lsb_rem  = lsb_red[W-1:0];
   assign wgt_dbl  = {wgt_base, 1'b0};
   assign wgt_red  = (wgt_dbl >= MODW) ? (wgt_dbl - MODW) : wgt_dbl;
   assign wgt_nxt  = wgt_red[W-1:0];
   assign rem_upd  = lsb_mode ? lsb_rem : msb_rem;

   always_comb begin
      wgt_d = wgt_q;
      lsb_d = lsb_q;
      if (accept) begin
         wgt_d = wgt_nxt;
         lsb_d = lsb_mode;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wgt_q <= W'(1);
         lsb_q <= 1'b0;
      end else begin
         wgt_q <= wgt_d;
         lsb_q <= lsb_d;
      end
   end
`else
   logic unused_lsb_first;
   assign unused_lsb_first = lsb_first;
   assign rem_upd          = msb_rem;
`endif

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (accept) begin
         rem_d   = rem_upd;
         state_d = in_eof ? DONE : RUN;
         // Length saturates at MAXLEN; any further bit marks the frame as overflowed.
         if (cnt_base == MAXC) begin
            cnt_d = cnt_base;
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_base + CW'(1);
            ovf_d = ovf_base;
         end
      end else if (state_q == DONE) begin
         // DONE lasts a single cycle regardless of in_valid so done is a true pulse.
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign rem       = rem_q;
   assign bit_cnt   = cnt_q;
   assign ovf       = ovf_q;
   assign done      = (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign divisible = (rem_q == '0) && (state_q != IDLE);

endmodule

// File: tb/tb_serial_mod_fsm.sv
// Self-checking bench for serial_mod_fsm: directed vector table, hand sequences and a
// randomized run against a value-level reference model (MOD=5, MAXLEN=4).
module tb_serial_mod_fsm;
   localparam int MOD    = 5;
   localparam int MAXLEN = 4;
   localparam int W      = 3;
   localparam int CW     = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_bit, in_sof, in_eof, lsb_first;
   logic [W-1:0]  rem;
   logic          divisible, done, busy, ovf;
   logic [CW-1:0] bit_cnt;

   int vecs = 0;
   int miss = 0;

   serial_mod_fsm #(.MOD(MOD), .MAXLEN(MAXLEN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
      .in_eof(in_eof), .lsb_first(lsb_first), .rem(rem), .divisible(divisible),
      .done(done), .busy(busy), .bit_cnt(bit_cnt), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference model: value-level bookkeeping of the current frame.
   bit m_in_frame, m_done, m_ovf, m_lsb;
   int m_rem, m_k;

   function automatic int pow2mod(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p = (p * 2) % MOD;
      return p;
   endfunction

   task automatic model_reset();
      m_in_frame = 0; m_done = 0; m_ovf = 0; m_lsb = 0; m_rem = 0; m_k = 0;
   endtask

   task automatic model_step();
      m_done = 0;
      if (in_valid && (in_sof || m_in_frame)) begin
         if (in_sof) begin
            m_rem = 0; m_k = 0; m_ovf = 0;
`ifdef SERIAL_MOD_LSB_FIRST_EN
            m_lsb = lsb_first;
`else
            m_lsb = 0;
`endif
         end
         if (m_lsb) m_rem = (m_rem + int'(in_bit) * pow2mod(m_k)) % MOD;
         else       m_rem = (2 * m_rem + int'(in_bit)) % MOD;
         m_k++;
         if (m_k > MAXLEN) m_ovf = 1;
         m_in_frame = !in_eof;
         m_done     = in_eof;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("m_rem",  32'(rem),       32'(m_rem));
      chk("m_done", 32'(done),      32'(m_done));
      chk("m_busy", 32'(busy),      32'(m_in_frame));
      chk("m_div",  32'(divisible), 32'((m_rem == 0) && (m_in_frame || m_done)));
      chk("m_cnt",  32'(bit_cnt),   32'((m_k > MAXLEN) ? MAXLEN : m_k));
      chk("m_ovf",  32'(ovf),       32'(m_ovf));
   endtask

   task automatic step(input bit v, input bit b, input bit s, input bit e, input bit l);
      in_valid = v; in_bit = b; in_sof = s; in_eof = e; lsb_first = l;
      @(posedge clk);
      model_step();
      #1;
      chk_model();
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_rem"},  32'(rem),       0);
      chk({nm, "_done"}, 32'(done),      0);
      chk({nm, "_busy"}, 32'(busy),      0);
      chk({nm, "_div"},  32'(divisible), 0);
      chk({nm, "_cnt"},  32'(bit_cnt),   0);
      chk({nm, "_ovf"},  32'(ovf),       0);
   endtask

   typedef struct {
      bit v, b, s, e;
      int rem, cnt;
      bit done, busy, div, ovf;
   } vec_t;

   function automatic vec_t mk(input bit v, b, s, e, input int r, c,
                               input bit dn, bs, dv, o);
      vec_t t;
      t.v = v; t.b = b; t.s = s; t.e = e; t.rem = r; t.cnt = c;
      t.done = dn; t.busy = bs; t.div = dv; t.ovf = o;
      return t;
   endfunction

   vec_t tbl[27];

   initial begin
      // value 11: rem 1,2,0,1; then idle and an ignored non-sof bit
      tbl[0]  = mk(1,1,1,0, 1,1, 0,1,0,0);
      tbl[1]  = mk(1,0,0,0, 2,2, 0,1,0,0);
      tbl[2]  = mk(1,1,0,0, 0,3, 0,1,1,0);
      tbl[3]  = mk(1,1,0,1, 1,4, 1,0,0,0);
      tbl[4]  = mk(0,0,0,0, 1,4, 0,0,0,0);
      tbl[5]  = mk(1,1,0,0, 1,4, 0,0,0,0);
      // gap of three invalid cycles (junk on sof/bit), then eof bit
      tbl[6]  = mk(1,1,1,0, 1,1, 0,1,0,0);
      tbl[7]  = mk(0,0,1,0, 1,1, 0,1,0,0);
      tbl[8]  = mk(0,1,1,1, 1,1, 0,1,0,0);
      tbl[9]  = mk(0,0,0,1, 1,1, 0,1,0,0);
      tbl[10] = mk(1,1,0,1, 3,2, 1,0,0,0);
      // abort by sof in RUN, no done for the aborted frame
      tbl[11] = mk(1,1,1,0, 1,1, 0,1,0,0);
      tbl[12] = mk(1,1,0,0, 3,2, 0,1,0,0);
      tbl[13] = mk(1,1,1,0, 1,1, 0,1,0,0);
      tbl[14] = mk(1,0,0,1, 2,2, 1,0,0,0);
      // six ones with MAXLEN=4 -> 63 mod 5 = 3, saturated count, ovf
      tbl[15] = mk(1,1,1,0, 1,1, 0,1,0,0);
      tbl[16] = mk(1,1,0,0, 3,2, 0,1,0,0);
      tbl[17] = mk(1,1,0,0, 2,3, 0,1,0,0);
      tbl[18] = mk(1,1,0,0, 0,4, 0,1,1,0);
      tbl[19] = mk(1,1,0,0, 1,4, 0,1,0,1);
      tbl[20] = mk(1,1,0,1, 3,4, 1,0,0,1);
      tbl[21] = mk(0,0,0,0, 3,4, 0,0,0,1);
      // one-bit frames back to back, then sof directly out of DONE
      tbl[22] = mk(1,1,1,1, 1,1, 1,0,0,0);
      tbl[23] = mk(1,0,1,1, 0,1, 1,0,1,0);
      tbl[24] = mk(1,1,1,0, 1,1, 0,1,0,0);
      tbl[25] = mk(1,0,0,1, 2,2, 1,0,0,0);
      tbl[26] = mk(0,0,0,0, 2,2, 0,0,0,0);

      rst = 1'b1; in_valid = 0; in_bit = 0; in_sof = 0; in_eof = 0; lsb_first = 0;
      model_reset();
      #2;
      chk_zero("reset");
      #10 rst = 1'b0;

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].e, 1'b0);
         chk($sformatf("t%0d_rem", i),  32'(rem),       32'(tbl[i].rem));
         chk($sformatf("t%0d_cnt", i),  32'(bit_cnt),   32'(tbl[i].cnt));
         chk($sformatf("t%0d_done", i), 32'(done),      32'(tbl[i].done));
         chk($sformatf("t%0d_busy", i), 32'(busy),      32'(tbl[i].busy));
         chk($sformatf("t%0d_div", i),  32'(divisible), 32'(tbl[i].div));
         chk($sformatf("t%0d_ovf", i),  32'(ovf),       32'(tbl[i].ovf));
      end

`ifdef SERIAL_MOD_LSB_FIRST_EN
      // LSB-first 1,1,1,1 = 15: rem 1,3,2,0, divisible at done
      step(1,1,1,0,1); chk("lsb0_rem", 32'(rem), 1);
      step(1,1,0,0,0); chk("lsb1_rem", 32'(rem), 3);
      step(1,1,0,0,0); chk("lsb2_rem", 32'(rem), 2);
      step(1,1,0,1,0); chk("lsb3_rem", 32'(rem), 0);
      chk("lsb_done", 32'(done), 1);
      chk("lsb_div",  32'(divisible), 1);
`endif

      // Mid-frame reset between edges: immediate zeros, no done, clean restart.
      step(1,1,1,0,0);
      step(1,1,0,0,0);
      #2 rst = 1'b1;
      #1 chk_zero("arst");
      @(posedge clk); #1 chk_zero("arst_hold");
      in_valid = 1; in_sof = 0; in_eof = 1;
      @(posedge clk); #1 chk_zero("arst_nodone");
      #2 rst = 1'b0;
      model_reset();
      step(1,1,1,0,0);
      step(1,0,0,0,0);
      step(1,1,0,0,0);
      step(1,1,0,1,0);
      chk("post_rst_rem",  32'(rem),  1);
      chk("post_rst_done", 32'(done), 1);

      for (int n = 0; n < 600; n++)
         step(($urandom % 4) != 0, $urandom % 2, ($urandom % 6) == 0,
              ($urandom % 6) == 0, $urandom % 2);
      step(0,0,0,0,0);
      step(0,0,0,0,0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

// File: doc/serial_mod_fsm.md
SERIAL_MOD_FSM -- requirements
Module: serial_mod_fsm

Interface
REQ-001 The block SHALL have parameter MOD, default 5, meaning the modulus, legal range 2..256.
REQ-002 The block SHALL have parameter MAXLEN, default 32, meaning the maximum frame length in bits before overflow is flagged.
REQ-003 The block SHALL define localparam W = $clog2(MOD), the remainder width, with a minimum of 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_bit, in_sof and in_eof are qualified this cycle.
REQ-007 The block SHALL have port in_bit, input, 1 bit: the serial data bit.
REQ-008 The block SHALL have port in_sof, input, 1 bit: the current bit is the first bit of a new number.
REQ-009 The block SHALL have port in_eof, input, 1 bit: the current bit is the last bit of the number.
REQ-010 The block SHALL have port lsb_first, input, 1 bit: bit-order select, sampled only on an accepted sof bit.
REQ-011 The block SHALL have port rem, output, W bits: the running remainder of the number received so far, mod MOD.
REQ-012 The block SHALL have port divisible, output, 1 bit: combinational (rem == 0) && (state != IDLE).
REQ-013 The block SHALL have port done, output, 1 bit: a one-cycle pulse, the final result is valid on rem.
REQ-014 The block SHALL have port busy, output, 1 bit: high while state == RUN.
REQ-015 The block SHALL have port bit_cnt, output, $clog2(MAXLEN+1) bits: accepted bits in the current frame, saturating at MAXLEN.
REQ-016 The block SHALL have port ovf, output, 1 bit: sticky, set when the frame exceeds MAXLEN bits, cleared on the next accepted sof.

Function
REQ-017 The state machine SHALL have states IDLE, RUN and DONE; it SHALL leave IDLE only on in_valid && in_sof.
REQ-018 An accepted bit is in_valid=1 in RUN, or in_valid && in_sof in any state; when in_valid=0, all registers SHALL hold.
REQ-019 In IDLE or DONE, in_valid with in_sof=0 SHALL be ignored.
REQ-020 In MSB-first mode, rem' SHALL be (2*rem + in_bit) mod MOD, computed in W+1 bits with a single conditional subtract of MOD (no divider).
REQ-021 In LSB-first mode, rem' SHALL be (rem + in_bit*wgt) mod MOD and wgt' SHALL be (2*wgt) mod MOD, each with a single conditional subtract.
REQ-022 On an accepted sof, the arithmetic SHALL start from rem=0, wgt=1, bit_cnt=0 and ovf=0, then apply the current bit.
REQ-023 An accepted sof in RUN SHALL abort the current frame and restart it; done SHALL NOT pulse for the aborted frame.
REQ-024 An accepted bit with in_eof=1 SHALL go to DONE and update rem at the same edge; done SHALL be high for exactly that next cycle.
REQ-025 A bit with in_sof=1 and in_eof=1 SHALL form a one-bit frame: RUN is skipped and the block goes straight to DONE.
REQ-026 DONE SHALL return to IDLE after one cycle, unless a sof is accepted in that cycle, in which case it SHALL go to RUN (or DONE again if in_eof is also high).
REQ-027 rem SHALL hold its last value in IDLE and DONE until the next accepted sof.
REQ-028 When an accepted bit arrives with bit_cnt == MAXLEN, ovf SHALL set; bit_cnt SHALL stay at MAXLEN; rem SHALL stay arithmetically exact.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, rem=0, wgt=1, bit_cnt=0, done=0, ovf=0, busy=0, divisible=0.
REQ-030 Reset mid-frame SHALL discard the frame with no done pulse; the first sof after rst falls SHALL be accepted normally.

Configuration
REQ-031 With macro SERIAL_MOD_LSB_FIRST_EN defined, the wgt register and LSB-first datapath SHALL be built, and lsb_first SHALL select the order per frame.
REQ-032 Without SERIAL_MOD_LSB_FIRST_EN, the block SHALL be MSB-first only: lsb_first is ignored and no wgt register is built.

Verification
REQ-033 MOD=5, MSB-first, bits 1,0,1,1 (value 11) -> rem 1,2,0,1; done pulses once; divisible=0 at done.
REQ-034 MOD=5, LSB-first (macro defined), bits 1,1,1,1 (value 15) -> rem 1,3,2,0; done with divisible=1.
REQ-035 MOD=5, MSB-first bits 1,1 with in_valid low for 3 cycles between them -> rem holds at 1 during the gap, then becomes 3.
REQ-036 MOD=5, MSB-first 1,1 then sof with bit 1 -> rem=1, bit_cnt=1, no done; then eof bit 0 -> rem=2, done.
REQ-037 MOD=5, MAXLEN=4, six 1-bits MSB-first (value 63) -> at done: rem=3, bit_cnt=4, ovf=1.
REQ-038 Assert rst between clock edges mid-frame -> all outputs zero immediately, no done; a new frame afterwards is correct.
